// File: rtl/fruit_launcher.sv
// fruit_launcher: NUM_FRUITS-slot projectile engine. Each slot is a tiny
// IDLE/FLYING FSM holding a signed position and velocity. A free-running
// Galois LFSR randomises launches. A spawn timer paces launch attempts.
// Slots retire on an accepted cut or when they leave the screen.
//
// Handshake: cut_valid/cut_idx form a single-cycle request with no back-pressure.
// A request is accepted only if it targets an in-range FLYING slot. Acceptance
// is reported by a one-cycle cut_ack pulse on the following edge.
// fruit_active mirrors the per-slot FSM state (1 = FLYING) and doubles as its
// debug view.
module fruit_launcher #(
  parameter int          NUM_FRUITS     = 4,
  parameter int          POS_W          = 10,
  parameter int          X_MAX          = 639,
  parameter int          Y_MAX          = 479,
  parameter int          GRAVITY        = 1,
  parameter int          LAUNCH_V       = 20,
  parameter int          SPAWN_INTERVAL = 60,
  parameter int          FRUIT_SIZE     = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                          frame_clk,
  input  logic                          Reset,
  input  logic                          enable,
  input  logic                          cut_valid,
  input  logic [2:0]                    cut_idx,
  output logic [NUM_FRUITS*POS_W-1:0]   fruit_x,
  output logic [NUM_FRUITS*POS_W-1:0]   fruit_y,
  output logic [NUM_FRUITS-1:0]         fruit_active,
  output logic [POS_W-1:0]              fruit_s,
  output logic                          cut_ack,
  output logic [NUM_FRUITS-1:0]         missed_mask,
  output logic [7:0]                    cut_count
);

  localparam int PW       = POS_W + 2;
  localparam int TW       = $clog2(SPAWN_INTERVAL + 1);
  localparam int HALF_INT = SPAWN_INTERVAL / 2;
  localparam logic signed [PW-1:0] X_LIM    = PW'(X_MAX);
  localparam logic signed [PW-1:0] Y_LIM    = PW'(Y_MAX);
  localparam logic signed [PW-1:0] POS_ZERO = '0;
  localparam logic signed [8:0]    GRAV9    = 9'(GRAVITY);
  localparam logic signed [8:0]    VMAX9    = 9'sd127;

  typedef enum logic {S_IDLE = 1'b0, S_FLYING = 1'b1} slot_state_e;

  slot_state_e          state_q [NUM_FRUITS];
  slot_state_e          state_d [NUM_FRUITS];
  logic signed [PW-1:0] x_q     [NUM_FRUITS];
  logic signed [PW-1:0] x_d     [NUM_FRUITS];
  logic signed [PW-1:0] y_q     [NUM_FRUITS];
  logic signed [PW-1:0] y_d     [NUM_FRUITS];
  logic signed [7:0]    vx_q    [NUM_FRUITS];
  logic signed [7:0]    vx_d    [NUM_FRUITS];
  logic signed [7:0]    vy_q    [NUM_FRUITS];
  logic signed [7:0]    vy_d    [NUM_FRUITS];
  logic signed [PW-1:0] nx      [NUM_FRUITS];
  logic signed [PW-1:0] ny      [NUM_FRUITS];
  logic signed [8:0]    vy_sum  [NUM_FRUITS];
  logic signed [7:0]    vy_next [NUM_FRUITS];

  logic [NUM_FRUITS-1:0] exit_hit, cut_hit, launch_hit;
  logic [NUM_FRUITS-1:0] missed_q, missed_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [TW-1:0]         timer_q, timer_d, reload;
  logic [5:0]            quarter;
  logic                  launch_try, free_seen;
  logic [7:0]            count_q, count_d;
  logic                  ack_q, ack_d;
  logic signed [PW-1:0]  launch_x;
  logic signed [7:0]     launch_vx, launch_vy;

  // Galois LFSR, taps 0xB400; free-running every edge.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Launch parameters drawn from the current LFSR value.
  assign launch_x  = PW'(64 + int'(lfsr_q[8:0]));
  assign launch_vx = 8'(int'(lfsr_q[11:9]) - 4);
  assign launch_vy = 8'(-(LAUNCH_V + int'(lfsr_q[14:12])));

  // Difficulty ramp: every four cuts shorten the interval by one frame, capped at half.
  assign quarter = count_q[7:2];
  assign reload  = (int'(quarter) < HALF_INT) ? TW'(SPAWN_INTERVAL - int'(quarter))
                                              : TW'(SPAWN_INTERVAL - HALF_INT);

  for (genvar g = 0; g < NUM_FRUITS; g++) begin : g_slot
    assign nx[g]       = x_q[g] + PW'(vx_q[g]);
    assign ny[g]       = y_q[g] + PW'(vy_q[g]);
    assign vy_sum[g]   = 9'(vy_q[g]) + GRAV9;
    assign vy_next[g]  = (vy_sum[g] > VMAX9) ? 8'sd127 : vy_sum[g][7:0];
    assign exit_hit[g] = ((ny[g] > Y_LIM) && (vy_q[g] > 8'sd0)) ||
                         (nx[g] < POS_ZERO) || (nx[g] > X_LIM);
    assign cut_hit[g]  = cut_valid && (cut_idx == 3'(g)) && (state_q[g] == S_FLYING);
    assign fruit_x[g*POS_W +: POS_W] = x_q[g][POS_W-1:0];
    assign fruit_y[g*POS_W +: POS_W] = y_q[g][POS_W-1:0];
    assign fruit_active[g]           = (state_q[g] == S_FLYING);
  end

  // Spawn timer: count down on enabled edges, attempt a launch and reload at zero.
  always_comb begin
    timer_d    = timer_q;
    launch_try = 1'b0;
    if (enable) begin
      if (timer_q == '0) begin
        launch_try = 1'b1;
        timer_d    = reload;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  // Pick the lowest-index slot that is idle at the start of this cycle.
  always_comb begin
    launch_hit = '0;
    free_seen  = 1'b0;
    for (int i = 0; i < NUM_FRUITS; i++) begin
      if (!free_seen && state_q[i] == S_IDLE) begin
        launch_hit[i] = launch_try;
        free_seen     = 1'b1;
      end
    end
  end

  // Per-slot next state: cut beats exit; flying slots move only while enabled.
  always_comb begin
    missed_d = '0;
    for (int i = 0; i < NUM_FRUITS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      vx_d[i]    = vx_q[i];
      vy_d[i]    = vy_q[i];
      if (cut_hit[i]) begin
        state_d[i] = S_IDLE;
        x_d[i] = '0; y_d[i] = '0; vx_d[i] = '0; vy_d[i] = '0;
      end else if (state_q[i] == S_FLYING && enable) begin
        if (exit_hit[i]) begin
          state_d[i]  = S_IDLE;
          missed_d[i] = 1'b1;
          x_d[i] = '0; y_d[i] = '0; vx_d[i] = '0; vy_d[i] = '0;
        end else begin
          x_d[i]  = nx[i];
          y_d[i]  = ny[i];
          vy_d[i] = vy_next[i];
        end
      end else if (launch_hit[i]) begin
        state_d[i] = S_FLYING;
        x_d[i]     = launch_x;
        y_d[i]     = Y_LIM;
        vx_d[i]    = launch_vx;
        vy_d[i]    = launch_vy;
      end
    end
  end

  // Cut acknowledge and saturating cut counter.
  always_comb begin
    ack_d   = |cut_hit;
    count_d = count_q;
    if (|cut_hit && count_q != 8'hFF) count_d = count_q + 8'd1;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_FRUITS; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        vx_q[i]    <= '0;
        vy_q[i]    <= '0;
      end
      lfsr_q   <= LFSR_SEED;
      timer_q  <= TW'(SPAWN_INTERVAL);
      count_q  <= '0;
      ack_q    <= 1'b0;
      missed_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FRUITS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        vx_q[i]    <= vx_d[i];
        vy_q[i]    <= vy_d[i];
      end
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      missed_q <= missed_d;
    end
  end

  assign cut_ack     = ack_q;
  assign missed_mask = missed_q;
  assign cut_count   = count_q;
  assign fruit_s     = POS_W'(FRUIT_SIZE);

endmodule

// File: tb/tb_fruit_launcher.sv
// Testbench for fruit_launcher: randomized stimulus, behavioural model,
// expected-output queue drained by an independent monitor.
module tb_fruit_launcher;

  localparam int NF = 4;
  localparam int PW = 10;
  localparam int SI = 8;
  localparam int XM = 639;
  localparam int YM = 479;
  localparam int G  = 1;
  localparam int LV = 20;
  localparam int FS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic cv  = 1'b0;
  logic [2:0] ci = 3'd0;
  always #5 clk = ~clk;

  logic [NF*PW-1:0] fruit_x, fruit_y;
  logic [NF-1:0]    fruit_active, missed_mask;
  logic [PW-1:0]    fruit_s;
  logic             cut_ack;
  logic [7:0]       cut_count;

  fruit_launcher #(.NUM_FRUITS(NF), .POS_W(PW), .SPAWN_INTERVAL(SI)) dut (
    .frame_clk    (clk),
    .Reset        (rst),
    .enable       (en),
    .cut_valid    (cv),
    .cut_idx      (ci),
    .fruit_x      (fruit_x),
    .fruit_y      (fruit_y),
    .fruit_active (fruit_active),
    .fruit_s      (fruit_s),
    .cut_ack      (cut_ack),
    .missed_mask  (missed_mask),
    .cut_count    (cut_count)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [NF*PW-1:0] x;
    logic [NF*PW-1:0] y;
    logic [NF-1:0]    act;
    logic             ack;
    logic [NF-1:0]    miss;
    logic [7:0]       cnt;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_x[NF], m_y[NF], m_vx[NF], m_vy[NF];
  bit          m_act[NF];
  int          m_timer, m_cnt;
  logic [15:0] m_lfsr;
  bit          m_ack;
  logic [NF-1:0] m_miss;

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_act[i] = 0;
    end
    m_timer = SI; m_cnt = 0; m_lfsr = 16'hACE1; m_ack = 0; m_miss = '0;
  endtask

  function automatic bit model_exit(int i);
    int nx = m_x[i] + m_vx[i];
    int ny = m_y[i] + m_vy[i];
    return m_act[i] && ((ny > YM && m_vy[i] > 0) || nx < 0 || nx > XM);
  endfunction

  // One frame of the game rules, applied to the inputs currently driven.
  task automatic model_step();
    bit start_act[NF];
    bit launch, cut_ok, placed;
    logic [15:0] nl;
    if (rst) begin
      model_reset();
      return;
    end
    nl = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    start_act = m_act;
    m_ack = 0; m_miss = '0; launch = 0;
    if (en) begin
      if (m_timer == 0) begin
        launch  = 1;
        m_timer = SI - (((m_cnt / 4) < (SI / 2)) ? (m_cnt / 4) : (SI / 2));
      end else begin
        m_timer = m_timer - 1;
      end
    end
    cut_ok = cv && (int'(ci) < NF) && m_act[ci];
    for (int i = 0; i < NF; i++) begin
      if (cut_ok && int'(ci) == i) begin
        m_act[i] = 0;
      end else if (m_act[i] && en) begin
        if (model_exit(i)) begin
          m_act[i] = 0; m_miss[i] = 1'b1;
        end else begin
          m_x[i]  = m_x[i] + m_vx[i];
          m_y[i]  = m_y[i] + m_vy[i];
          m_vy[i] = (m_vy[i] + G > 127) ? 127 : m_vy[i] + G;
        end
      end
    end
    if (cut_ok) begin
      m_ack = 1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
    placed = 0;
    if (launch) begin
      for (int i = 0; i < NF; i++) begin
        if (!placed && !start_act[i]) begin
          placed  = 1;
          m_act[i] = 1;
          m_x[i]  = 64 + int'(m_lfsr[8:0]);
          m_y[i]  = YM;
          m_vx[i] = int'(m_lfsr[11:9]) - 4;
          m_vy[i] = -(LV + int'(m_lfsr[14:12]));
        end
      end
    end
    m_lfsr = nl;
  endtask

  task automatic push_exp();
    exp_t e;
    e = '0;
    for (int i = 0; i < NF; i++) begin
      e.x[i*PW +: PW] = PW'(m_x[i]);
      e.y[i*PW +: PW] = PW'(m_y[i]);
      e.act[i]        = m_act[i];
    end
    e.ack  = m_ack;
    e.miss = m_miss;
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic r, input logic e, input logic v, input logic [2:0] idx);
    @(negedge clk);
    rst = r; en = e; cv = v; ci = idx;
    model_step();
    push_exp();
  endtask

  task automatic reset_midflight();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; cv = 1'b0;
    #1;
    check("async_reset_active", 32'(fruit_active), 0);
    check("async_reset_count", 32'(cut_count), 0);
    check("async_reset_ack", 32'(cut_ack), 0);
    check("async_reset_missed", 32'(missed_mask), 0);
    check("async_reset_x_zero", 32'(fruit_x != '0), 0);
    check("async_reset_y_zero", 32'(fruit_y != '0), 0);
    model_step();
    push_exp();
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fruit_active", 32'(fruit_active), 32'(e.act));
        check("cut_ack", 32'(cut_ack), 32'(e.ack));
        check("missed_mask", 32'(missed_mask), 32'(e.miss));
        check("cut_count", 32'(cut_count), 32'(e.cnt));
        check("fruit_s", 32'(fruit_s), FS);
        for (int i = 0; i < NF; i++) begin
          if (e.act[i]) begin
            check($sformatf("fruit_x[%0d]", i), 32'(fruit_x[i*PW +: PW]), 32'(e.x[i*PW +: PW]));
            check($sformatf("fruit_y[%0d]", i), 32'(fruit_y[i*PW +: PW]), 32'(e.y[i*PW +: PW]));
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: stimulus did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic v;
    logic [2:0] idx;
    model_reset();
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 3'd0);

    // Light cutting; deliberately slice some fruit on the frame they would exit.
    for (int k = 0; k < 400; k++) begin
      v   = 1'b0;
      idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin
        v = 1'b1;
      end else begin
        for (int i = 0; i < NF; i++) begin
          if (model_exit(i) && $urandom_range(0, 1) == 1) begin
            v = 1'b1; idx = 3'(i);
          end
        end
      end
      drive_cycle(1'b0, 1'b1, v, idx);
    end

    // Reset while fruit are in flight, then release.
    reset_midflight();
    drive_cycle(1'b1, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 600; k++)
      drive_cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)));

    // Ten-frame freeze with a cut in the middle of it.
    for (int k = 0; k < 10; k++)
      drive_cycle(1'b0, 1'b0, 1'(k == 5), 3'($urandom_range(0, NF - 1)));

    // Heavy cutting to drive the counter into saturation.
    for (int k = 0; k < 3000; k++)
      drive_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)));

    // Saturated counter: shortest spawn interval, occasional cuts.
    for (int k = 0; k < 300; k++)
      drive_cycle(1'b0, 1'b1, 1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
    check("model_saturated", 32'(m_cnt), 255);

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
